// File: rtl/hh_pkg.sv
// Shared constants and helpers for the neuron/synapse chain.
// Default synapse tuning lives here so both ends agree.
package hh_pkg;

    localparam int I_MAX            = 255;
    localparam int WEIGHT_DEF       = 32;
    localparam int DECAY_SHIFT_DEF  = 3;
    localparam int DECAY_PERIOD_DEF = 4;
    localparam int REFRACT_DEF      = 2;
    localparam int WINDOW_DEF       = 64;

    function automatic logic [7:0] sat_add8(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'(I_MAX) : s[7:0];
    endfunction

endpackage

// File: rtl/hh_rate_counter.sv
// Fixed-window spike rate meter.
// Reports accepted spikes per window, saturating at 255.
module hh_rate_counter
    import hh_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit,
    output logic [7:0] rate_count,
    output logic       rate_valid
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] W_LAST = CW'(WINDOW - 1);

    logic [CW-1:0] window_cnt;
    logic [7:0]    acc;
    logic [7:0]    acc_inc;

    assign acc_inc = sat_add8(acc, {7'd0, hit});

    // Window counter; on the last cycle publish the total and restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_cnt <= '0;
            acc        <= 8'd0;
            rate_count <= 8'd0;
            rate_valid <= 1'b0;
        end else if (window_cnt == W_LAST) begin
            window_cnt <= '0;
            acc        <= 8'd0;
            rate_count <= acc_inc;
            rate_valid <= 1'b1;
        end else begin
            window_cnt <= window_cnt + CW'(1);
            acc        <= acc_inc;
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hh_synapse.sv
// Synapse: spike edges become a decaying current for the
// next neuron, plus a windowed spike-rate readout.
module hh_synapse
    import hh_pkg::*;
#(
    parameter int WEIGHT       = WEIGHT_DEF,
    parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
    parameter int DECAY_PERIOD = DECAY_PERIOD_DEF,
    parameter int REFRACT      = REFRACT_DEF,
    parameter int WINDOW       = WINDOW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spike_in,
    output logic [7:0] stim_current,
    output logic       event_pulse,
    output logic [7:0] rate_count,
    output logic       rate_valid
);

    localparam int PW =
        (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int RW =
        (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DECAY_PERIOD - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(REFRACT);
    localparam logic [7:0]    W8     = 8'(WEIGHT);

    logic          spike_any;
    logic          spike_q;
    logic          hit;
    logic          tick;
    logic [PW-1:0] prescaler;
    logic [RW-1:0] refract_cnt;
    logic [7:0]    shr;
    logic [7:0]    decayed;
    logic [7:0]    cur_nxt;

    assign spike_any = |spike_in;
    assign hit  = spike_any & ~spike_q & (refract_cnt == '0);
    assign tick = (prescaler == P_LAST);

    // Decay first, then add weight; small currents step down by 1
    // so the current always drains to zero.
    always_comb begin
        shr     = stim_current >> DECAY_SHIFT;
        decayed = stim_current;
        if (tick) begin
            if (stim_current != 8'd0 && shr == 8'd0)
                decayed = stim_current - 8'd1;
            else
                decayed = stim_current - shr;
        end
        cur_nxt = hit ? sat_add8(decayed, W8) : decayed;
    end

    // Edge detect, refractory, prescaler and current registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_q      <= 1'b0;
            event_pulse  <= 1'b0;
            stim_current <= 8'd0;
            prescaler    <= '0;
            refract_cnt  <= '0;
        end else begin
            spike_q      <= spike_any;
            event_pulse  <= hit;
            stim_current <= cur_nxt;
            prescaler    <= tick ? '0 : prescaler + PW'(1);
            if (hit)
                refract_cnt <= R_LOAD;
            else if (refract_cnt != '0)
                refract_cnt <= refract_cnt - RW'(1);
        end
    end

    hh_rate_counter #(
        .WINDOW(WINDOW)
    ) u_rate (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (hit),
        .rate_count(rate_count),
        .rate_valid(rate_valid)
    );

endmodule

// File: tb/tb_hh_synapse.sv
// Scoreboard bench for hh_synapse with default parameters.
// Cycle n means the n-th posedge after reset release.
module tb_hh_synapse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] spike_in = 8'd0;
    logic [7:0] stim_current;
    logic       event_pulse;
    logic [7:0] rate_count;
    logic       rate_valid;

    int n_chk = 0;
    int n_fail = 0;
    int n_ev = 0;
    int t = 0;
    int ev0;
    int ev_q[$];
    int rate_q[$];

    int seq1[21] = '{28, 25, 22, 20, 18, 16, 14, 13, 12, 11,
                     10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    int sat_ev[16] = '{32, 60, 92, 113, 131, 147, 179, 189,
                       198, 206, 238, 241, 243, 245, 255, 255};
    int pat2[6] = '{1, 0, 1, 0, 0, 1};
    int t5_at[8] = '{2, 10, 20, 30, 40, 64, 70, 80};
    int t5_ev[8] = '{32, 57, 71, 88, 92, 75, 98, 99};

    always #5 clk = ~clk;

    hh_synapse dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_in    (spike_in),
        .stim_current(stim_current),
        .event_pulse (event_pulse),
        .rate_count  (rate_count),
        .rate_valid  (rate_valid)
    );

    task automatic check(input string name, input int act,
                         input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a pulse appears.
    always @(negedge clk) begin
        if (event_pulse) begin
            n_ev++;
            if (ev_q.size() == 0)
                check("unexpected_event", int'(stim_current), -1);
            else
                check("event_stim", int'(stim_current),
                      ev_q.pop_front());
        end
        if (rate_valid) begin
            if (rate_q.size() == 0)
                check("unexpected_rate", int'(rate_count), -1);
            else
                check("rate_count", int'(rate_count),
                      rate_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        spike_in = 8'd0;
        step();
        step();
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic pulse_at(input int n, input logic [7:0] v);
        run_to(n - 1);
        spike_in = v;
        step();
        spike_in = 8'd0;
    endtask

    task automatic end_test(input string name);
        check({name, "_evq_left"}, ev_q.size(), 0);
        check({name, "_rateq_left"}, rate_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single held spike, then full decay to zero
        do_reset();
        check("rst_stim", int'(stim_current), 0);
        check("rst_event", int'(event_pulse), 0);
        check("rst_rate", int'(rate_count), 0);
        check("rst_valid", int'(rate_valid), 0);
        ev0 = n_ev;
        ev_q.push_back(32);
        rate_q.push_back(1);
        spike_in = 8'h01;
        step();
        step();
        step();
        spike_in = 8'h00;
        for (int k = 0; k < 21; k++) begin
            run_to(4 * (k + 1));
            check($sformatf("decay_%0d", k),
                  int'(stim_current), seq1[k]);
        end
        run_to(96);
        check("decay_hold0", int'(stim_current), 0);
        check("t1_events", n_ev - ev0, 1);
        end_test("t1");

        // 2: refractory masks the second edge
        do_reset();
        ev0 = n_ev;
        ev_q.push_back(32);
        ev_q.push_back(60);
        for (int i = 0; i < 6; i++) begin
            spike_in = (pat2[i] != 0) ? 8'h04 : 8'h00;
            step();
        end
        spike_in = 8'h00;
        run_to(10);
        check("t2_events", n_ev - ev0, 2);
        end_test("t2");

        // 3: dense spikes drive the current into saturation
        do_reset();
        ev0 = n_ev;
        foreach (sat_ev[i]) ev_q.push_back(sat_ev[i]);
        for (int k = 0; k < 16; k++) begin
            pulse_at(1 + 3 * k, 8'h80);
            if (k == 14) begin
                run_to(44);
                check("sat_decay", int'(stim_current), 224);
            end
        end
        run_to(47);
        check("sat_hold", int'(stim_current), 255);
        check("t3_events", n_ev - ev0, 16);
        end_test("t3");

        // 4: hit on a tick cycle: decay then weight
        do_reset();
        ev_q.push_back(32);
        ev_q.push_back(54);
        ev_q.push_back(80);
        ev_q.push_back(102);
        pulse_at(1, 8'h01);
        pulse_at(13, 8'h02);
        run_to(16);
        check("t4_pre48", int'(stim_current), 48);
        pulse_at(17, 8'h01);
        run_to(19);
        check("t4_pre80", int'(stim_current), 80);
        pulse_at(20, 8'h40);
        check("t4_tickhit", int'(stim_current), 102);
        run_to(24);
        check("t4_after", int'(stim_current), 90);
        end_test("t4");

        // 5: rate window incl. spike on the last window cycle
        do_reset();
        foreach (t5_ev[i]) ev_q.push_back(t5_ev[i]);
        rate_q.push_back(6);
        rate_q.push_back(2);
        foreach (t5_at[i]) pulse_at(t5_at[i], 8'h01);
        run_to(100);
        check("rate_hold", int'(rate_count), 6);
        run_to(130);
        check("rate_win1", int'(rate_count), 2);
        end_test("t5");

        // 6: reset mid-operation with spike held through it
        do_reset();
        ev0 = n_ev;
        for (int i = 0; i < 6; i++) ev_q.push_back(sat_ev[i]);
        for (int k = 0; k < 6; k++) pulse_at(1 + 3 * k, 8'h10);
        step();
        check("t6_pre_rst", int'(stim_current), 147);
        rst_n = 1'b0;
        spike_in = 8'hFF;
        step();
        check("t6_rst_stim", int'(stim_current), 0);
        check("t6_rst_event", int'(event_pulse), 0);
        check("t6_rst_rate", int'(rate_count), 0);
        check("t6_rst_valid", int'(rate_valid), 0);
        rst_n = 1'b1;
        t = 0;
        ev_q.push_back(32);
        ev_q.push_back(57);
        rate_q.push_back(2);
        run_to(5);
        spike_in = 8'h00;
        pulse_at(10, 8'h01);
        run_to(66);
        check("t6_events", n_ev - ev0, 8);
        end_test("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
